au_neg_seq: RTL



---
 rtl/au_neg_seq.sv | 118 +++++++++++
 1 files changed

// File: rtl/au_neg_seq.sv
// Digit-serial two's-complement negator (z = -a mod 2^WIDTH), DIGIT bits per clock from the LSB.
// Latency N = WIDTH/DIGIT cycles from acceptance to out_valid; result holds while out_ready=0.
// Optional AU_NEG_SEQ_ABS_EN adds abs_mode: non-negative operands pass through unchanged.
module au_neg_seq #(
  parameter int WIDTH = 8,
  parameter int DIGIT = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
`ifdef AU_NEG_SEQ_ABS_EN
  input  logic             abs_mode,
`endif
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] z,
  output logic             ovf
);

  localparam int N  = WIDTH / DIGIT;
  localparam int CW = (N > 1) ? $clog2(N) : 1;
  localparam logic [CW-1:0]    LAST     = CW'(N - 1);
  localparam logic [WIDTH-1:0] MOST_NEG = {1'b1, {(WIDTH-1){1'b0}}};

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t           state;
  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] opr;
  logic [WIDTH-1:0] res;
  logic             carry;
  logic             ovf_q;
`ifdef AU_NEG_SEQ_ABS_EN
  logic             pass_q;
`endif

  logic [DIGIT-1:0] a_dig;
  logic [DIGIT-1:0] d;
  logic [DIGIT:0]   sum;
  logic             c_next;
  logic [WIDTH-1:0] res_shift;

  assign a_dig = opr[DIGIT-1:0];

  always_comb begin
    sum    = {1'b0, ~a_dig} + {{DIGIT{1'b0}}, carry};
    d      = sum[DIGIT-1:0];
    c_next = sum[DIGIT];
`ifdef AU_NEG_SEQ_ABS_EN
    // Pass-through digit: equivalent to no inversion and a zero carry chain.
    if (pass_q) begin
      d      = a_dig;
      c_next = 1'b0;
    end
`endif
  end

  // New digits enter from the MSB so the LSB digit lands at bit 0 after N shifts.
  generate
    if (N == 1) begin : g_single
      assign res_shift = d;
    end else begin : g_multi
      assign res_shift = {d, res[WIDTH-1:DIGIT]};
    end
  endgenerate

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      cnt    <= '0;
      opr    <= '0;
      res    <= '0;
      carry  <= 1'b0;
      ovf_q  <= 1'b0;
`ifdef AU_NEG_SEQ_ABS_EN
      pass_q <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            opr    <= a;
            carry  <= 1'b1;
            cnt    <= '0;
            ovf_q  <= (a == MOST_NEG);
`ifdef AU_NEG_SEQ_ABS_EN
            pass_q <= abs_mode & ~a[WIDTH-1];
`endif
            state  <= BUSY;
          end
        end
        BUSY: begin
          opr   <= opr >> DIGIT;
          res   <= res_shift;
          carry <= c_next;
          if (cnt == LAST) begin
            cnt   <= '0;
            state <= DONE;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        DONE: begin
          if (out_ready) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);
  assign z         = res;
  assign ovf       = ovf_q;

endmodule
